axi4_lite_master_read_fsm: RTL and testbench
============================================

Name: axi4_lite_master_read_fsm

Overview:
- Single-outstanding AXI4-Lite read master controlled by a simple user request/response port.
- A one-cycle USR_ENA pulse launches one read: address phase (ARVALID/ARREADY), then data phase (RVALID/RREADY).
- Returned data is byte-masked by USR_WSTB and delivered to the user side with a one-cycle done pulse.
- Sits between user logic and an AXI4-Lite slave/interconnect; it is the read-channel half of the master.

Parameters:
- ADDR_WIDTH, 32, width of ARADDR/USR_ADDR.
- DATA_WIDTH, 32, width of RDATA/USR_RDATA; must be 32 (USR_WSTB is 4 bits).
- ARPROT_VAL, 3'b000, constant driven on ARPROT.

Ports:
- ACLK  in  1  clock; all logic on rising edge.
- ARESETn  in  1  asynchronous active-low reset.
- ARVALID  out  1  read address valid.
- ARREADY  in  1  read address ready from slave.
- ARADDR  out  ADDR_WIDTH  read address.
- ARPROT  out  3  protection, always ARPROT_VAL.
- RVALID  in  1  read data valid from slave.
- RREADY  out  1  read data ready.
- RDATA  in  DATA_WIDTH  read data.
- RRESP  in  2  read response.
- USR_ENA  in  1  start request, sampled only in IDLE.
- USR_ADDR  in  ADDR_WIDTH  read address, captured with USR_ENA.
- USR_WSTB  in  4  byte-lane mask, captured with USR_ENA; lane i kept when bit i = 1.
- USR_RDATA  out  DATA_WIDTH  masked read data, held until the next capture.
- USR_RRESP  out  2  captured RRESP.
- USR_DONE  out  1  one-cycle pulse when the read completes.
- USR_BUSY  out  1  high whenever state is not IDLE.

Behaviour:
- States: IDLE, ADDR, DATA, DONE (2-bit encoding).
- Reset (ARESETn=0, asynchronous):
  - State goes to IDLE.
  - ARVALID, RREADY, USR_DONE, USR_BUSY are 0.
  - ARADDR, USR_RDATA, USR_RRESP are 0; the latched strobe is 0.
- IDLE:
  - If USR_ENA=1 at a clock edge: latch USR_ADDR into ARADDR, latch USR_WSTB, go to ADDR.
  - Otherwise stay in IDLE.
- ADDR:
  - ARVALID=1 (registered output, high from the first ADDR cycle).
  - ARVALID and ARADDR stay stable until the handshake; ARVALID never drops without ARREADY.
  - On an edge with ARVALID&ARREADY: go to DATA; ARVALID=0 and RREADY=1 in the next cycle.
- DATA:
  - RREADY=1.
  - On an edge with RVALID&RREADY: USR_RDATA = RDATA with byte lane i zeroed where latched strobe bit i = 0; USR_RRESP = RRESP; RREADY=0; go to DONE.
- DONE:
  - USR_DONE=1 for exactly one cycle, then go to IDLE.
  - The next request is accepted no earlier than the cycle after DONE.
- ARVALID and RREADY are never high together. RREADY is asserted only in DATA.
- ARREADY or RVALID arriving early (before ARVALID or RREADY is high) is ignored; no handshake counts.
- USR_ENA while not IDLE is ignored; no queuing.
- Slave-side stalls have unbounded wait; there is no timeout.
- RRESP values are passed through without interpretation.
- Minimum latency with zero-wait slave, counting the USR_ENA edge as edge 0:
  - ARVALID high after edge 0.
  - Address handshake at edge 1.
  - Data handshake at edge 2.
  - USR_DONE high after edge 2 for one cycle.
- Reset mid-transaction aborts immediately; outputs return to reset values with no completion pulse.

Test Plan:
- Reset: hold ARESETn=0 for 3 cycles -> ARVALID=0, RREADY=0, USR_DONE=0, USR_BUSY=0, USR_RDATA=0.
- Basic read:
  - Stimulus: USR_ENA one-cycle pulse with USR_ADDR=0x10, USR_WSTB=4'b1111; slave raises ARREADY one cycle after ARVALID for one cycle; RVALID one cycle after RREADY with RDATA=0xDEADBEEF, RRESP=0.
  - Response: ARVALID high 2 cycles with ARADDR=0x10; RREADY high 2 cycles; USR_RDATA=0xDEADBEEF; USR_DONE pulses once; never ARVALID&RREADY together.
- Byte mask: same read with USR_WSTB=4'b0101, RDATA=0x11223344 -> USR_RDATA=0x00220044.
- Stall: ARREADY delayed 5 cycles, RVALID delayed 4 cycles -> ARVALID and ARADDR stable throughout, RREADY held, exactly one USR_DONE.
- Busy ignore: second USR_ENA with USR_ADDR=0x20 pulsed during DATA -> ignored, ARADDR stays 0x10, only one transaction issued.
- Abort: assert ARESETn=0 while in DATA -> RREADY drops asynchronously, no USR_DONE; after release, a new read with RRESP=2'b10 completes with USR_RRESP=2'b10.

Source files
------------

// File: rtl/axi4_lite_master_read_fsm.sv
// AXI4-Lite read master, one read in flight at a time.
// A single-cycle USR_ENA launches an address phase then a data phase.
// The returned word is byte-masked by the strobe captured with the request
// and handed back together with a one-cycle done pulse.
module axi4_lite_master_read_fsm #(
    parameter int          ADDR_WIDTH = 32,
    parameter int          DATA_WIDTH = 32,   // lane masking assumes four byte lanes
    parameter logic [2:0]  ARPROT_VAL = 3'b000
) (
    input  logic                  ACLK,
    input  logic                  ARESETn,
    // AXI4-Lite read address channel
    output logic                  ARVALID,
    input  logic                  ARREADY,
    output logic [ADDR_WIDTH-1:0] ARADDR,
    output logic [2:0]            ARPROT,
    // AXI4-Lite read data channel
    input  logic                  RVALID,
    output logic                  RREADY,
    input  logic [DATA_WIDTH-1:0] RDATA,
    input  logic [1:0]            RRESP,
    // user request / response side
    input  logic                  USR_ENA,
    input  logic [ADDR_WIDTH-1:0] USR_ADDR,
    input  logic [3:0]            USR_WSTB,
    output logic [DATA_WIDTH-1:0] USR_RDATA,
    output logic [1:0]            USR_RRESP,
    output logic                  USR_DONE,
    output logic                  USR_BUSY
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t                  state_q;
    logic                    arvalid_q;
    logic                    rready_q;
    logic [ADDR_WIDTH-1:0]   araddr_q;
    logic [3:0]              wstb_q;
    logic [DATA_WIDTH-1:0]   usrRdata_q;
    logic [DATA_WIDTH-1:0]   usrRdata_d;
    logic [1:0]              usrRresp_q;
    logic                    usrDone_q;
    logic                    usrBusy_q;

    // Zero every byte lane of the incoming read data whose latched strobe bit is clear.
    always_comb begin
        usrRdata_d = RDATA;
        for (int i = 0; i < 4; i++) begin
            if (!wstb_q[i]) begin
                usrRdata_d[8*i +: 8] = 8'h00;
            end
        end
    end

    // Transaction sequencer; every handshake and user output is registered here.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q    <= IDLE;
            arvalid_q  <= 1'b0;
            rready_q   <= 1'b0;
            araddr_q   <= '0;
            wstb_q     <= 4'b0000;
            usrRdata_q <= '0;
            usrRresp_q <= 2'b00;
            usrDone_q  <= 1'b0;
            usrBusy_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    usrDone_q <= 1'b0;
                    if (USR_ENA) begin
                        araddr_q  <= USR_ADDR;
                        wstb_q    <= USR_WSTB;
                        arvalid_q <= 1'b1;
                        usrBusy_q <= 1'b1;
                        state_q   <= ADDR;
                    end
                end
                ADDR: begin
                    // ARVALID is already high here, so ARREADY alone completes the handshake
                    if (ARREADY) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= DATA;
                    end
                end
                DATA: begin
                    if (RVALID) begin
                        usrRdata_q <= usrRdata_d;
                        usrRresp_q <= RRESP;
                        rready_q   <= 1'b0;
                        usrDone_q  <= 1'b1;
                        state_q    <= DONE;
                    end
                end
                DONE: begin
                    usrDone_q <= 1'b0;
                    usrBusy_q <= 1'b0;
                    state_q   <= IDLE;
                end
                default: begin
                    arvalid_q <= 1'b0;
                    rready_q  <= 1'b0;
                    usrDone_q <= 1'b0;
                    usrBusy_q <= 1'b0;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

    assign ARVALID   = arvalid_q;
    assign ARADDR    = araddr_q;
    assign ARPROT    = ARPROT_VAL;
    assign RREADY    = rready_q;
    assign USR_RDATA = usrRdata_q;
    assign USR_RRESP = usrRresp_q;
    assign USR_DONE  = usrDone_q;
    assign USR_BUSY  = usrBusy_q;

endmodule

// File: tb/tb_axi4_lite_master_read_fsm.sv
// Self-checking bench for the AXI4-Lite read master.
// The bench plays the slave with chosen wait states and predicts every
// user-side result from the request alone (lane masking by arithmetic).
module tb_axi4_lite_master_read_fsm;

    logic        ACLK;
    logic        ARESETn;
    logic        ARVALID;
    logic        ARREADY;
    logic [31:0] ARADDR;
    logic [2:0]  ARPROT;
    logic        RVALID;
    logic        RREADY;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        USR_ENA;
    logic [31:0] USR_ADDR;
    logic [3:0]  USR_WSTB;
    logic [31:0] USR_RDATA;
    logic [1:0]  USR_RRESP;
    logic        USR_DONE;
    logic        USR_BUSY;

    int checks = 0;
    int errors = 0;

    axi4_lite_master_read_fsm #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .ARPROT_VAL (3'b000)
    ) dut (
        .ACLK      (ACLK),
        .ARESETn   (ARESETn),
        .ARVALID   (ARVALID),
        .ARREADY   (ARREADY),
        .ARADDR    (ARADDR),
        .ARPROT    (ARPROT),
        .RVALID    (RVALID),
        .RREADY    (RREADY),
        .RDATA     (RDATA),
        .RRESP     (RRESP),
        .USR_ENA   (USR_ENA),
        .USR_ADDR  (USR_ADDR),
        .USR_WSTB  (USR_WSTB),
        .USR_RDATA (USR_RDATA),
        .USR_RRESP (USR_RRESP),
        .USR_DONE  (USR_DONE),
        .USR_BUSY  (USR_BUSY)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        ACLK = 1'b0;
        forever #5 ACLK = ~ACLK;
    end

    // Reference: keep byte lane i of the data only when strobe bit i is set.
    function automatic logic [31:0] maskedWord(input logic [31:0] data, input logic [3:0] wstb);
        logic [31:0] result;
        result = 32'h0;
        for (int i = 0; i < 4; i++) begin
            if (wstb[i]) result = result + (data & (32'hFF << (8 * i)));
        end
        return result;
    endfunction

    // One complete read: the bench acts as slave, stalling arDelay cycles before
    // ARREADY and rDelay cycles before RVALID, and checks every cycle on the way.
    task automatic runRead(input logic [31:0] addr, input logic [3:0] wstb,
                           input logic [31:0] data, input logic [1:0] resp,
                           input int arDelay, input int rDelay,
                           input bit injectEna, input bit earlyPulse);
        logic [31:0] expData;
        expData = maskedWord(data, wstb);

        @(negedge ACLK);
        USR_ENA  = 1'b1;
        USR_ADDR = addr;
        USR_WSTB = wstb;
        ARREADY  = earlyPulse;
        RVALID   = earlyPulse;
        RDATA    = $urandom;
        RRESP    = 2'b11;

        @(negedge ACLK);
        USR_ENA  = 1'b0;
        USR_ADDR = $urandom;
        USR_WSTB = 4'($urandom);
        ARREADY  = 1'b0;

        for (int c = 0; c <= arDelay; c++) begin
            checks++;
            if (ARVALID !== 1'b1) begin
                errors++;
                $display("[TB] FAIL addr_phase_arvalid cycle %0d got %b want 1", c, ARVALID);
            end
            checks++;
            if (ARADDR !== addr) begin
                errors++;
                $display("[TB] FAIL addr_phase_araddr cycle %0d got %h want %h", c, ARADDR, addr);
            end
            checks++;
            if (RREADY !== 1'b0) begin
                errors++;
                $display("[TB] FAIL addr_phase_rready cycle %0d got %b want 0", c, RREADY);
            end
            checks++;
            if (USR_BUSY !== 1'b1 || ARPROT !== 3'b000) begin
                errors++;
                $display("[TB] FAIL addr_phase_busy_prot got %b/%b want 1/000", USR_BUSY, ARPROT);
            end
            RVALID  = (c == arDelay) ? 1'b0 : earlyPulse;
            ARREADY = (c == arDelay);
            @(negedge ACLK);
        end
        ARREADY = 1'b0;
        RVALID  = 1'b0;

        for (int c = 0; c <= rDelay; c++) begin
            checks++;
            if (ARVALID !== 1'b0) begin
                errors++;
                $display("[TB] FAIL data_phase_arvalid cycle %0d got %b want 0", c, ARVALID);
            end
            checks++;
            if (RREADY !== 1'b1) begin
                errors++;
                $display("[TB] FAIL data_phase_rready cycle %0d got %b want 1", c, RREADY);
            end
            checks++;
            if (USR_DONE !== 1'b0 || USR_BUSY !== 1'b1) begin
                errors++;
                $display("[TB] FAIL data_phase_done_busy got %b/%b want 0/1", USR_DONE, USR_BUSY);
            end
            checks++;
            if (ARADDR !== addr) begin
                errors++;
                $display("[TB] FAIL data_phase_araddr got %h want %h", ARADDR, addr);
            end
            if (injectEna && c == 0) begin
                USR_ENA  = 1'b1;
                USR_ADDR = addr ^ 32'h30;
                USR_WSTB = 4'b0000;
            end
            if (c == rDelay) begin
                RVALID = 1'b1;
                RDATA  = data;
                RRESP  = resp;
            end
            @(negedge ACLK);
            USR_ENA = 1'b0;
        end
        RVALID = 1'b0;
        RDATA  = $urandom;
        RRESP  = 2'($urandom);

        checks++;
        if (USR_DONE !== 1'b1) begin
            errors++;
            $display("[TB] FAIL done_pulse got %b want 1", USR_DONE);
        end
        checks++;
        if (USR_RDATA !== expData) begin
            errors++;
            $display("[TB] FAIL usr_rdata got %h want %h", USR_RDATA, expData);
        end
        checks++;
        if (USR_RRESP !== resp) begin
            errors++;
            $display("[TB] FAIL usr_rresp got %b want %b", USR_RRESP, resp);
        end
        checks++;
        if (RREADY !== 1'b0 || ARVALID !== 1'b0) begin
            errors++;
            $display("[TB] FAIL done_handshakes_low got %b/%b want 0/0", RREADY, ARVALID);
        end

        @(negedge ACLK);
        checks++;
        if (USR_DONE !== 1'b0 || USR_BUSY !== 1'b0) begin
            errors++;
            $display("[TB] FAIL after_done got done/busy %b/%b want 0/0", USR_DONE, USR_BUSY);
        end
        checks++;
        if (USR_RDATA !== expData || ARVALID !== 1'b0) begin
            errors++;
            $display("[TB] FAIL after_done_hold got %h/%b want %h/0", USR_RDATA, ARVALID, expData);
        end
    endtask

    task automatic test_reset();
        ARESETn = 1'b0;
        repeat (3) @(negedge ACLK);
        checks++;
        if (ARVALID !== 1'b0 || RREADY !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_handshakes got %b/%b want 0/0", ARVALID, RREADY);
        end
        checks++;
        if (USR_DONE !== 1'b0 || USR_BUSY !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_done_busy got %b/%b want 0/0", USR_DONE, USR_BUSY);
        end
        checks++;
        if (USR_RDATA !== 32'h0 || USR_RRESP !== 2'b00 || ARADDR !== 32'h0) begin
            errors++;
            $display("[TB] FAIL reset_data got %h/%b/%h want 0/0/0", USR_RDATA, USR_RRESP, ARADDR);
        end
        ARESETn = 1'b1;
    endtask

    task automatic test_basic_read();
        runRead(32'h10, 4'b1111, 32'hDEADBEEF, 2'b00, 1, 1, 1'b0, 1'b0);
    endtask

    task automatic test_min_latency();
        runRead(32'h44, 4'b1111, 32'hCAFEF00D, 2'b01, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic test_byte_mask();
        runRead(32'h10, 4'b0101, 32'h11223344, 2'b00, 1, 1, 1'b0, 1'b0);
    endtask

    task automatic test_stall();
        runRead(32'h10, 4'b1111, 32'hA5A55A5A, 2'b00, 5, 4, 1'b0, 1'b0);
    endtask

    task automatic test_early_ignored();
        runRead(32'h80, 4'b1010, 32'h89ABCDEF, 2'b11, 2, 2, 1'b0, 1'b1);
    endtask

    task automatic test_busy_ignore();
        runRead(32'h10, 4'b1111, 32'h01020304, 2'b00, 1, 2, 1'b1, 1'b0);
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (ARVALID !== 1'b0 || USR_BUSY !== 1'b0) begin
                errors++;
                $display("[TB] FAIL busy_ignore_no_second got %b/%b want 0/0", ARVALID, USR_BUSY);
            end
            @(negedge ACLK);
        end
    endtask

    task automatic test_abort();
        @(negedge ACLK);
        USR_ENA  = 1'b1;
        USR_ADDR = 32'h1234;
        USR_WSTB = 4'b1111;
        @(negedge ACLK);
        USR_ENA = 1'b0;
        ARREADY = 1'b1;
        @(negedge ACLK);
        ARREADY = 1'b0;
        checks++;
        if (RREADY !== 1'b1) begin
            errors++;
            $display("[TB] FAIL abort_in_data got rready %b want 1", RREADY);
        end
        #2 ARESETn = 1'b0;
        #1;
        checks++;
        if (RREADY !== 1'b0 || ARVALID !== 1'b0 || USR_BUSY !== 1'b0) begin
            errors++;
            $display("[TB] FAIL abort_async got %b/%b/%b want 0/0/0", RREADY, ARVALID, USR_BUSY);
        end
        checks++;
        if (USR_RDATA !== 32'h0 || ARADDR !== 32'h0) begin
            errors++;
            $display("[TB] FAIL abort_clear got %h/%h want 0/0", USR_RDATA, ARADDR);
        end
        RVALID = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge ACLK);
            checks++;
            if (USR_DONE !== 1'b0 || RREADY !== 1'b0) begin
                errors++;
                $display("[TB] FAIL abort_no_done got %b/%b want 0/0", USR_DONE, RREADY);
            end
        end
        RVALID  = 1'b0;
        ARESETn = 1'b1;
        runRead(32'h2000, 4'b1111, 32'h55667788, 2'b10, 0, 1, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 12; n++) begin
            runRead($urandom, 4'($urandom), $urandom, 2'($urandom),
                    int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
                    1'($urandom), 1'($urandom));
        end
    endtask

    // Scenario sequence, then the summary line.
    initial begin
        ARESETn  = 1'b0;
        ARREADY  = 1'b0;
        RVALID   = 1'b0;
        RDATA    = 32'h0;
        RRESP    = 2'b00;
        USR_ENA  = 1'b0;
        USR_ADDR = 32'h0;
        USR_WSTB = 4'b0000;
        test_reset();
        test_basic_read();
        test_min_latency();
        test_byte_mask();
        test_stall();
        test_early_ignored();
        test_busy_ignore();
        test_abort();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
